// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter sharing one 4B memory port.
// Ports: req0/req1 (imem/dmem) request + response channels, memreq/memresp
// toward memory, num_outstanding = requests issued but not yet answered.
module mem_port_arbiter #(
    parameter int p_max_outstanding = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [76:0] req0_msg,
    input  logic        req0_val,
    output logic        req0_rdy,
    output logic [46:0] resp0_msg,
    output logic        resp0_val,
    input  logic        resp0_rdy,

    input  logic [76:0] req1_msg,
    input  logic        req1_val,
    output logic        req1_rdy,
    output logic [46:0] resp1_msg,
    output logic        resp1_val,
    input  logic        resp1_rdy,

    output logic [76:0] memreq_msg,
    output logic        memreq_val,
    input  logic        memreq_rdy,
    input  logic [46:0] memresp_msg,
    input  logic        memresp_val,
    output logic        memresp_rdy,

    output logic [$clog2(p_max_outstanding):0] num_outstanding
);

    localparam int c_ptr_w = $clog2(p_max_outstanding);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic               prio_q,   prio_d;
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] cnt_q,    cnt_d;
    // One requester id per in-flight request, in issue order.
    logic [p_max_outstanding-1:0] fifo_q, fifo_d;

    logic grant;
    logic can_issue;
    logic empty;
    logic head;
    logic req_fire;
    logic resp_fire;

    // Credit is based on the registered count only, so a response
    // popping this cycle never frees a slot until the next cycle.
    assign can_issue = (cnt_q < c_cnt_w'(p_max_outstanding));
    assign empty     = (cnt_q == '0);
    assign head      = fifo_q[rd_ptr_q];

    always_comb begin
        if (req0_val && req1_val) begin
            grant = prio_q;
        end else begin
            grant = req1_val;
        end
    end

    // All handshake outputs are forced low while reset is held.
    always_comb begin
        memreq_msg  = grant ? req1_msg : req0_msg;
        memreq_val  = ~reset & can_issue & (grant ? req1_val : req0_val);
        req0_rdy    = ~reset & can_issue & memreq_rdy & ~grant;
        req1_rdy    = ~reset & can_issue & memreq_rdy & grant;
        resp0_msg   = memresp_msg;
        resp1_msg   = memresp_msg;
        resp0_val   = ~reset & ~empty & memresp_val & ~head;
        resp1_val   = ~reset & ~empty & memresp_val & head;
        memresp_rdy = ~reset & ~empty & (head ? resp1_rdy : resp0_rdy);
    end

    assign req_fire  = memreq_val & memreq_rdy;
    assign resp_fire = memresp_val & memresp_rdy;

    always_comb begin
        prio_d   = prio_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        fifo_d   = fifo_q;
        if (req_fire) begin
            fifo_d[wr_ptr_q] = grant;
            wr_ptr_d         = wr_ptr_q + c_ptr_w'(1);
            prio_d           = ~grant;
        end
        if (resp_fire) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end
        if (req_fire && !resp_fire) begin
            cnt_d = cnt_q + c_cnt_w'(1);
        end else if (!req_fire && resp_fire) begin
            cnt_d = cnt_q - c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            prio_q   <= prio_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign num_outstanding = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed
// by randomized traffic, all checked against a queue-based model.
module tb_mem_port_arbiter;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [76:0] req0_msg, req1_msg, memreq_msg;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [46:0] resp0_msg, resp1_msg, memresp_msg;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
    logic [2:0]  num_outstanding;

    int checks = 0;
    int errors = 0;

    // Model: ids of in-flight requests (oldest first), preferred
    // requester for the next contested grant, and the memory's own
    // queue of accepted requests awaiting a response.
    int          q[$];
    bit          pref;
    logic [76:0] mq[$];

    mem_port_arbiter #(.p_max_outstanding(P)) dut (
        .clk(clk), .reset(reset),
        .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val),
        .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val),
        .memresp_rdy(memresp_rdy),
        .num_outstanding(num_outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [76:0] obs,
                        input logic [76:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [76:0] mk_req(input logic [31:0] addr);
        // type, opaque, addr, len, data
        mk_req = {3'd0, 8'($urandom), addr, 2'd0, 32'($urandom)};
    endfunction

    function automatic logic [76:0] rnd77();
        rnd77 = {13'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    // Memory returns responses strictly in request order.
    task automatic drive_mem(input int pct);
        memresp_msg = 47'($urandom);
        memresp_val = 1'b0;
        if (mq.size() > 0 && $urandom_range(99) < pct) begin
            memresp_val = 1'b1;
            memresp_msg = {3'd0, mq[0][73:66], 2'd0, 2'd0, mq[0][31:0]};
        end
    endtask

    // One clock: check every output against the model just before the
    // edge, then advance the model with the handshakes it predicted.
    task automatic tick();
        bit  can, g, e_mval, e_r0, e_r1, e_v0, e_v1, e_mr, rf, pf;
        #1;
        rf = 0;
        pf = 0;
        g  = 0;
        if (reset) begin
            chk1("rst_memreq_val", memreq_val, 1'b0);
            chk1("rst_req0_rdy", req0_rdy, 1'b0);
            chk1("rst_req1_rdy", req1_rdy, 1'b0);
            chk1("rst_resp0_val", resp0_val, 1'b0);
            chk1("rst_resp1_val", resp1_val, 1'b0);
            chk1("rst_memresp_rdy", memresp_rdy, 1'b0);
        end else begin
            can = q.size() < P;
            g = (req0_val && req1_val) ? pref : req1_val;
            e_mval = can && (g ? req1_val : req0_val);
            e_r0 = can && memreq_rdy && !g;
            e_r1 = can && memreq_rdy && g;
            e_v0 = 0;
            e_v1 = 0;
            e_mr = 0;
            if (q.size() > 0) begin
                e_v0 = memresp_val && q[0] == 0;
                e_v1 = memresp_val && q[0] == 1;
                e_mr = (q[0] == 1) ? resp1_rdy : resp0_rdy;
            end
            chk1("memreq_val", memreq_val, e_mval);
            chk1("req0_rdy", req0_rdy, e_r0);
            chk1("req1_rdy", req1_rdy, e_r1);
            chk1("resp0_val", resp0_val, e_v0);
            chk1("resp1_val", resp1_val, e_v1);
            chk1("memresp_rdy", memresp_rdy, e_mr);
            chkw("num_outstanding", 77'(num_outstanding), 77'(q.size()));
            chkw("resp0_msg", 77'(resp0_msg), 77'(memresp_msg));
            chkw("resp1_msg", 77'(resp1_msg), 77'(memresp_msg));
            if (e_mval)
                chkw("memreq_msg", memreq_msg, g ? req1_msg : req0_msg);
            rf = e_mval && memreq_rdy;
            pf = memresp_val && e_mr;
        end
        @(posedge clk);
        if (reset) begin
            q.delete();
            mq.delete();
            pref = 0;
        end else begin
            if (pf) begin
                void'(q.pop_front());
                void'(mq.pop_front());
            end
            if (rf) begin
                q.push_back(int'(g));
                mq.push_back(memreq_msg);
                pref = !g;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_val = 0; req1_val = 0;
        req0_msg = rnd77(); req1_msg = rnd77();
        memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
        memresp_val = 0; memresp_msg = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        pref = 0;
        reset = 1;
        idle_inputs();
        @(negedge clk);
        tick();
        tick();
        reset = 0;

        // Requester 0 alone: three reads, memory answers as soon as it can.
        for (int i = 0; i < 3; i++) begin
            req0_val = 1;
            req0_msg = mk_req(32'h100 + 32'(4 * i));
            drive_mem(100);
            tick();
        end
        req0_val = 0;
        repeat (4) begin
            drive_mem(100);
            tick();
        end
        #1 chkw("t1_drained", 77'(num_outstanding), 77'(0));
        @(negedge clk);

        // Both valid every cycle: grants alternate starting with 0.
        do_reset();
        req0_val = 1;
        req1_val = 1;
        req0_msg = mk_req(32'h200);
        req1_msg = mk_req(32'h300);
        drive_mem(100);
        #1 chk1("t2_first_grant0", req0_rdy, 1'b1);
        chk1("t2_first_not1", req1_rdy, 1'b0);
        tick();
        drive_mem(100);
        #1 chk1("t2_second_grant1", req1_rdy, 1'b1);
        tick();
        repeat (4) begin
            req0_msg = rnd77();
            req1_msg = rnd77();
            drive_mem(100);
            tick();
        end
        req0_val = 0;
        req1_val = 0;
        repeat (6) begin
            drive_mem(100);
            tick();
        end

        // Memory holds responses: only four may be in flight.
        do_reset();
        memresp_val = 0;
        req0_val = 1;
        req1_val = 1;
        repeat (5) tick();
        #1 chkw("t3_full_count", 77'(num_outstanding), 77'(4));
        chk1("t3_full_req0_rdy", req0_rdy, 1'b0);
        chk1("t3_full_req1_rdy", req1_rdy, 1'b0);
        chk1("t3_full_memreq_val", memreq_val, 1'b0);
        drive_mem(100);
        #1 chk1("t3_no_same_cycle_credit", memreq_val, 1'b0);
        tick();
        memresp_val = 0;
        #1 chk1("t3_issue_next_cycle", memreq_val, 1'b1);
        tick();
        req0_val = 0;
        req1_val = 0;
        repeat (6) begin
            drive_mem(100);
            tick();
        end

        // Interleaved 0,1,0 with requester 0 stalling its response.
        do_reset();
        req0_val = 1; tick();
        req0_val = 0; req1_val = 1; tick();
        req1_val = 0; req0_val = 1; tick();
        req0_val = 0;
        resp0_rdy = 0;
        repeat (3) begin
            drive_mem(100);
            #1 chk1("t4_hol_memresp_rdy", memresp_rdy, 1'b0);
            chk1("t4_hol_resp1_val", resp1_val, 1'b0);
            tick();
        end
        resp0_rdy = 1;
        repeat (4) begin
            drive_mem(100);
            tick();
        end

        // Spurious memory response with nothing in flight.
        memresp_val = 1;
        memresp_msg = 47'($urandom);
        #1 chk1("t5_spurious_rdy", memresp_rdy, 1'b0);
        tick();
        tick();
        #1 chkw("t5_count", 77'(num_outstanding), 77'(0));
        @(negedge clk);

        // Reset with two in flight discards them.
        memresp_val = 0;
        req0_val = 1;
        req1_val = 1;
        repeat (2) tick();
        #1 chkw("t6_pre_count", 77'(num_outstanding), 77'(2));
        @(negedge clk);
        do_reset();
        memresp_val = 1;
        #1 chkw("t6_count", 77'(num_outstanding), 77'(0));
        chk1("t6_grant0", req0_rdy, 1'b1);
        chk1("t6_stale_resp", memresp_rdy, 1'b0);
        tick();

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(149) == 0);
            req0_val = $urandom_range(99) < 60;
            req1_val = $urandom_range(99) < 60;
            req0_msg = rnd77();
            req1_msg = rnd77();
            memreq_rdy = $urandom_range(99) < 75;
            resp0_rdy = $urandom_range(99) < 70;
            resp1_rdy = $urandom_range(99) < 70;
            drive_mem(50);
            if (mq.size() == 0 && $urandom_range(9) == 0)
                memresp_val = 1;
            tick();
        end
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
